// File: rtl/muldiv_seq_if.sv
// Issue, MTHI/MTLO and result signals shared between the execute stage and
// the multi-cycle multiply/divide sequencer.
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, op_x, op_y, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, op_x, op_y, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// One bit per cycle: 32 RUN iterations, then a FIX cycle that applies signs.
module muldiv_seq (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        sign_x;
  logic        sign_y;
  logic        y_zero;
  logic [31:0] orig_x;
  logic [31:0] a_q;      // multiplier, or dividend shifting into quotient
  logic [31:0] b_q;      // multiplicand, or divisor
  logic [63:0] acc;      // product, or remainder in the upper half
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        dz_q;

  logic        start_signed;
  logic [31:0] abs_x;
  logic [31:0] abs_y;
  logic [32:0] mul_sum;
  logic [63:0] mul_acc_nxt;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [31:0] div_rem_nxt;
  logic [31:0] div_quo_nxt;
  logic        op_signed;
  logic        op_div;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    start_signed = ~bus.op[0];
    abs_x        = (start_signed && bus.op_x[31]) ? -bus.op_x : bus.op_x;
    abs_y        = (start_signed && bus.op_y[31]) ? -bus.op_y : bus.op_y;

    mul_sum      = {1'b0, acc[63:32]} + (a_q[0] ? {1'b0, b_q} : 33'd0);
    mul_acc_nxt  = {mul_sum, acc[31:1]};

    // Restoring step: a failed trial leaves rem_sh below the divisor, so it fits 32 bits.
    rem_sh       = {acc[63:32], a_q[31]};
    div_diff     = {1'b0, rem_sh} - {2'b00, b_q};
    div_ok       = ~div_diff[33];
    div_rem_nxt  = div_ok ? div_diff[31:0] : rem_sh[31:0];
    div_quo_nxt  = {a_q[30:0], div_ok};

    op_signed    = ~op_q[0];
    op_div       = op_q[1];
    prod         = (op_signed && (sign_x ^ sign_y)) ? -acc : acc;
    quo          = (op_signed && (sign_x ^ sign_y)) ? -a_q : a_q;
    rem          = (op_signed && sign_x) ? -acc[63:32] : acc[63:32];

    fix_hi       = prod[63:32];
    fix_lo       = prod[31:0];
    if (op_div) begin
      fix_hi = y_zero ? orig_x : rem;
      fix_lo = y_zero ? 32'hFFFF_FFFF : quo;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      sign_x <= 1'b0;
      sign_y <= 1'b0;
      y_zero <= 1'b0;
      orig_x <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sign_x <= start_signed & bus.op_x[31];
            sign_y <= start_signed & bus.op_y[31];
            y_zero <= (bus.op_y == 32'd0);
            orig_x <= bus.op_x;
            a_q    <= bus.op[1] ? abs_x : abs_y;
            b_q    <= bus.op[1] ? abs_y : abs_x;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            if (op_div) begin
              acc[63:32] <= div_rem_nxt;
              a_q        <= div_quo_nxt;
            end else begin
              acc <= mul_acc_nxt;
              a_q <= {1'b0, a_q[31:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            dz_q   <= op_div & y_zero;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed spec vectors, randomized ops
// against an arithmetic reference model, MTHI/MTLO, start/flush/reset corners.
module tb_muldiv_seq;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  // Architectural result of one op computed with plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    case (op)
      2'd0: p = sx * sy;
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) p = 64'd0;
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = (y == 0) ? 64'd0 : {x % y, x / y};
    endcase
    hi = p[63:32];
    lo = p[31:0];
    if (op[1] && y == 0) begin
      hi = x;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.op    = op;
    bus.op_x  = x;
    bus.op_y  = y;
    bus.start = 1'b1;
  endtask

  // Called right after issue(); returns at the negedge where done is seen.
  task automatic wait_done(output int lat, output int busy_cnt, output logic ok);
    lat = 0;
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) $display("FAIL timeout: no done within %0d cycles", lat);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
               bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[7];
    int   lat, bcnt;
    logic ok;
    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'd3, 32'd100,       32'd7,         32'h2,         32'hE,         1'b0};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[5] = '{2'd3, 32'd5,         32'd0,         32'h5,         32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{2'd3, 32'd9,         32'd3,         32'h0,         32'h3,         1'b0};
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y);
      wait_done(lat, bcnt, ok);
      tests_run++;
      if (bus.hi !== vecs[i].hi || bus.lo !== vecs[i].lo || bus.div_zero !== vecs[i].dz) begin
        tests_failed++;
        $display("FAIL directed[%0d] result: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, bus.hi, bus.lo, bus.div_zero, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      end
      tests_run++;
      if (lat !== 34 || bcnt !== 33) begin
        tests_failed++;
        $display("FAIL directed[%0d] timing: latency=%0d busy_cycles=%0d, required 34 and 33",
                 i, lat, bcnt);
      end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed[%0d] pulse: done=%b dz=%b one cycle later, required 0",
                 i, bus.done, bus.div_zero);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] special[5];
    logic [31:0] x, y, ehi, elo;
    logic [1:0]  op;
    logic        edz, ok;
    int          lat, bcnt;
    special = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      x  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      y  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      model(op, x, y, ehi, elo, edz);
      issue(op, x, y);
      wait_done(lat, bcnt, ok);
      tests_run++;
      if (bus.hi !== ehi || bus.lo !== elo || bus.div_zero !== edz || lat !== 34) begin
        tests_failed++;
        $display("FAIL random[%0d] op=%0d x=%h y=%h: hi=%h lo=%h dz=%b lat=%0d, required hi=%h lo=%h dz=%b lat=34",
                 n, op, x, y, bus.hi, bus.lo, bus.div_zero, lat, ehi, elo, edz);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lat, bcnt;
    logic ok;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt, ok);
    issue(2'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat, bcnt, ok);
    tests_run++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'h0 || lat !== 34) begin
      tests_failed++;
      $display("FAIL back_to_back: hi=%h lo=%h lat=%0d, required hi=1 lo=0 lat=34",
               bus.hi, bus.lo, lat);
    end
  endtask

  task automatic test_mthi_mtlo();
    int   lat, bcnt;
    logic ok;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_AAAA;
    @(negedge clk);
    bus.hi_we = 1'b0;
    tests_run++;
    if (bus.hi !== 32'h0000_AAAA) begin
      tests_failed++;
      $display("FAIL mthi: hi=%h, required 0000aaaa", bus.hi);
    end
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    tests_run++;
    if (bus.lo !== 32'h0000_5555 || bus.hi !== 32'h0000_AAAA) begin
      tests_failed++;
      $display("FAIL mtlo: hi=%h lo=%h, required 0000aaaa 00005555", bus.hi, bus.lo);
    end
    // Write while busy is dropped.
    issue(2'd1, 32'd2, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    tests_run++;
    if (bus.hi !== 32'h0000_AAAA || bus.lo !== 32'h0000_5555) begin
      tests_failed++;
      $display("FAIL write_busy: hi=%h lo=%h, required 0000aaaa 00005555", bus.hi, bus.lo);
    end
    wait_done(lat, bcnt, ok);
    tests_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd6) begin
      tests_failed++;
      $display("FAIL write_busy_result: hi=%h lo=%h, required 0 6", bus.hi, bus.lo);
    end
    // Start and write enable together: start wins.
    issue(2'd1, 32'd7, 32'd8);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    tests_run++;
    if (bus.hi !== 32'h0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_vs_we: hi=%h busy=%b, required hi=0 busy=1", bus.hi, bus.busy);
    end
    wait_done(lat, bcnt, ok);
    tests_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd56) begin
      tests_failed++;
      $display("FAIL start_vs_we_result: hi=%h lo=%h, required 0 56", bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_ignored();
    int lat, dones;
    lat = 0;
    dones = 0;
    issue(2'd0, 32'd3, 32'd4);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) issue(2'd1, 32'd5, 32'd5);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    tests_run++;
    if (lat !== 34 || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
      tests_failed++;
      $display("FAIL start_busy: lat=%0d hi=%h lo=%h, required lat=34 hi=0 lo=12",
               lat, bus.hi, bus.lo);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL start_queued: %0d busy/done cycles after completion, required 0", dones);
    end
  endtask

  task automatic test_flush();
    int   dones;
    logic busy_after;
    dones = 0;
    busy_after = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1111;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_2222;
    @(negedge clk);
    bus.lo_we = 1'b0;
    issue(2'd0, 32'd3, 32'd4);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = (c == 10);
      if (c == 11) busy_after = bus.busy;
      if (bus.done) dones++;
    end
    tests_run++;
    if (busy_after !== 1'b0 || dones !== 0) begin
      tests_failed++;
      $display("FAIL flush: busy_next=%b dones=%0d, required 0 0", busy_after, dones);
    end
    tests_run++;
    if (bus.hi !== 32'h0000_1111 || bus.lo !== 32'h0000_2222) begin
      tests_failed++;
      $display("FAIL flush_hold: hi=%h lo=%h, required 00001111 00002222", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    int   lat, bcnt;
    logic ok;
    issue(2'd0, 32'd3, 32'd4);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
               bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'd0, 32'd3, 32'd4);
    wait_done(lat, bcnt, ok);
    tests_run++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd12 || lat !== 34) begin
      tests_failed++;
      $display("FAIL reset_rerun: hi=%h lo=%h lat=%0d, required 0 12 34", bus.hi, bus.lo, lat);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.op_x  = '0;
    bus.op_y  = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    @(negedge clk);
    test_mthi_mtlo();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU, sitting beside the single-cycle ALU in the execute stage. The ALU has no room for 64-bit products or division, so this block owns those operations and the HI/LO registers. It uses an iterative one-bit-per-cycle shift-add (multiply) or restoring-subtract (divide) engine. It raises `busy` so the pipeline stalls HI/LO consumers until results are written.

## Interface
- No parameters; width is fixed at 32.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin an operation; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `op_x` input 32: rs operand (multiplicand / dividend).
- `op_y` input 32: rt operand (multiplier / divisor).
- `flush` input 1: synchronous abort of an in-flight operation.
- `hi_we`, `lo_we` input 1 each: MTHI/MTLO write enables.
- `wdata` input 32: MTHI/MTLO data.
- `hi`, `lo` output 32: architectural HI/LO registers.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when HI/LO receive a result.
- `div_zero` output 1: qualifies `done`; high when the completed divide had `op_y == 0`.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN on `start`.
  - RUN → FIX after the 32nd iteration.
  - FIX → IDLE unconditionally.
- `busy = (state != IDLE)`, combinational from the state register.
- Start capture (IDLE):
  - Latch `op`.
  - For signed ops, latch sign_x, sign_y and take absolute values. |0x80000000| = 0x80000000, treated as unsigned.
  - Clear the 64-bit accumulator and a 5-bit iteration counter.
- RUN, multiply: each cycle, if multiplier LSB is 1, add the multiplicand into the upper accumulator half with a 33-bit carry. Then shift the accumulator and multiplier right by 1.
- RUN, divide: each cycle, shift {rem, quo} left by 1, then trial-subtract the divisor from rem. If the result is non-negative, keep it and set quotient bit 1.
- FIX, then write HI/LO:
  - Signed multiply: if sign_x ^ sign_y, negate the full 64-bit product. HI = product[63:32], LO = product[31:0].
  - Signed divide: quotient negated if sign_x ^ sign_y; remainder negated if sign_x. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO = 0x80000000, HI = 0 (wraps, no trap).
  - Divide by zero: HI = original `op_x`, LO = 0xFFFFFFFF, `div_zero` = 1 with `done`. Latency is unchanged.
- MTHI/MTLO: in IDLE with `start` low, `hi_we`/`lo_we` load `wdata` on the edge.
  - Ignored while busy.
  - If `start` and a write enable are both high in IDLE, `start` wins and the write is dropped.
- `start` while busy: ignored; no queueing.
- `flush` while busy: next edge returns to IDLE. HI/LO are unchanged, no `done`. `flush` in IDLE has no effect; if `start` and `flush` are both high in IDLE, `start` wins.
- Reset (`rst_n` low, any time, including mid-operation) forces:
  - state IDLE
  - `hi` = `lo` = 0
  - `busy` = `done` = `div_zero` = 0
  - counter and accumulator cleared

## Timing
- Edge E0 samples `start`; `busy` is high from E0 until E33.
- E1–E32: the 32 RUN iterations.
- E33: FIX writes HI/LO and enters IDLE.
- `done` and `div_zero` are registered and high for exactly the cycle after E33. `hi`/`lo` are valid in that same cycle.
- Latency from `start` to `done`: 34 cycles, independent of op and operand values.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one op per 34 cycles.
- MTHI/MTLO take effect on the next edge with no further latency.

## Test plan
- MULT −1 × 7 (0xFFFFFFFF, 0x7) → HI = 0xFFFFFFFF, LO = 0xFFFFFFF9; `done` exactly 34 cycles after `start`; `busy` high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Back-to-back MULTU 0x10000 × 0x10000 issued in the `done` cycle → HI = 0x1, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 0xE, HI = 0x2. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → HI = 5, LO = 0xFFFFFFFF, `div_zero` = 1 with `done`. Following DIVU 9 / 3 → `div_zero` = 0, LO = 3, HI = 0.
- MTHI 0xAAAA and MTLO 0x5555 in IDLE → HI/LO updated next edge. A write during busy is dropped. `start` with `hi_we` in the same cycle → write dropped, operation runs.
- Start MULT 3 × 4 and:
  - Assert `start` (MULTU) at cycle 5 → ignored.
  - `flush` at cycle 10 → `busy` low next cycle, HI/LO hold prior values, no `done`.
  - Repeat the MULT, then drop `rst_n` at cycle 20 → all outputs 0 immediately; clean 3 × 4 = 12 after release.
